cache_ctrl_burst: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache controller. It is the successor to the single-word controller. Tag, valid and dirty state are held internally, and line fills and evictions are multi-beat bursts. The block sits between the CPU load/store port and the memory bus, and drives an external line-data RAM.

---
 rtl/cache_ctrl_burst_if.sv | 39 +++
 rtl/cache_ctrl_burst.sv | 130 +++++++++++++
 tb/tb_cache_ctrl_burst.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_burst_if.sv
// cache_ctrl_burst_if: bundles the CPU port, memory burst bus and data-RAM port of cache_ctrl_burst.
// slave  = the cache controller; master = the CPU / memory / line-RAM side.
// CPU:  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be -> ; <- cpu_rdata, cpu_ready
// MEM:  <- mem_req, mem_we, mem_addr, mem_wdata ; mem_rdata, mem_ready ->
// RAM:  <- ram_addr, ram_we, ram_be, ram_wdata ; ram_rdata -> (combinational read)
interface cache_ctrl_burst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int INDEX_W = 8,
  parameter int WORDS_PER_LINE = 4
);
  localparam int RAM_AW = INDEX_W + $clog2(WORDS_PER_LINE);
  logic cpu_req;
  logic cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W/8-1:0] cpu_be;
  logic [DATA_W-1:0] cpu_rdata;
  logic cpu_ready;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_ready;
  logic [RAM_AW-1:0] ram_addr;
  logic ram_we;
  logic [DATA_W/8-1:0] ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ready, ram_rdata,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, ram_addr, ram_we, ram_be, ram_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata, mem_ready, ram_rdata,
    input cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, ram_addr, ram_we, ram_be, ram_wdata
  );
endinterface

// File: rtl/cache_ctrl_burst.sv
// cache_ctrl_burst: direct-mapped write-back/write-allocate cache controller with burst fill and eviction.
// Ports: clk, rst_n (sync, active-low), bus (cache_ctrl_burst_if.slave: CPU, memory and data-RAM sides),
// hit_count/miss_count (first-lookup statistics, built only when CACHE_STATS_EN is defined, else 0).
module cache_ctrl_burst #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int INDEX_W = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input logic clk,
  input logic rst_n,
  cache_ctrl_burst_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - INDEX_W - WOFF_W - BYTE_W;
  localparam int LINE_AW = ADDR_W - BYTE_W;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
  state_t state, state_n;
  logic [WOFF_W-1:0] beat;
  logic req_we;
  logic [LINE_AW-1:0] req_line;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic [TAG_W-1:0] tag_mem [1 << INDEX_W];
  logic [(1 << INDEX_W)-1:0] valid, dirty;
  logic [TAG_W-1:0] tag;
  logic [INDEX_W-1:0] index;
  logic [WOFF_W-1:0] word;
  logic hit, last, beat_go, fill_done;
  assign tag = req_line[LINE_AW-1 -: TAG_W];
  assign index = req_line[WOFF_W +: INDEX_W];
  assign word = req_line[WOFF_W-1:0];
  assign hit = valid[index] && tag_mem[index] == tag;
  assign last = beat == WOFF_W'(WORDS_PER_LINE - 1);
  assign beat_go = (state == WRITE_BACK || state == ALLOCATE) && bus.mem_ready;
  assign fill_done = state == ALLOCATE && bus.mem_ready && last;
  always_comb begin
    state_n = state;
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.ram_addr = '0;
    bus.ram_we = 1'b0;
    bus.ram_be = '0;
    bus.ram_wdata = '0;
    case (state)
      IDLE: state_n = bus.cpu_req ? COMPARE : IDLE;
      COMPARE: begin
        bus.ram_addr = {index, word};
        if (hit) begin
          bus.cpu_ready = 1'b1;
          bus.cpu_rdata = req_we ? '0 : bus.ram_rdata;
          bus.ram_we = req_we;
          bus.ram_be = req_we ? req_be : '0;
          bus.ram_wdata = req_we ? req_wdata : '0;
          state_n = IDLE;
        end else begin
          state_n = valid[index] && dirty[index] ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        bus.mem_req = 1'b1;
        bus.mem_we = 1'b1;
        bus.mem_addr = ADDR_W'({tag_mem[index], index, beat}) << BYTE_W;
        bus.ram_addr = {index, beat};
        bus.mem_wdata = bus.ram_rdata;
        state_n = bus.mem_ready && last ? ALLOCATE : WRITE_BACK;
      end
      ALLOCATE: begin
        bus.mem_req = 1'b1;
        bus.mem_addr = ADDR_W'({tag, index, beat}) << BYTE_W;
        bus.ram_addr = {index, beat};
        bus.ram_we = bus.mem_ready;
        bus.ram_be = bus.mem_ready ? '1 : '0;
        bus.ram_wdata = bus.mem_ready ? bus.mem_rdata : '0;
        state_n = fill_done ? COMPARE : ALLOCATE;
      end
    endcase
  end
  // beat wraps to 0 after the last beat because WORDS_PER_LINE is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      beat <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_n;
      if (beat_go) beat <= beat + WOFF_W'(1);
      if (state == COMPARE && hit && req_we) dirty[index] <= 1'b1;
      if (beat_go && last) dirty[index] <= 1'b0;
      if (fill_done) valid[index] <= 1'b1;
    end
  end
  // tag write is gated by rst_n so a reset on the final fill beat leaves no partial update
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cpu_req) begin
      req_we <= bus.cpu_we;
      req_line <= bus.cpu_addr[ADDR_W-1:BYTE_W];
      req_wdata <= bus.cpu_wdata;
      req_be <= bus.cpu_be;
    end
    if (rst_n && fill_done) tag_mem[index] <= tag;
  end
`ifdef CACHE_STATS_EN
  // refill marks the post-fill re-lookup so it is not counted a second time
  logic refill;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count <= '0;
      miss_count <= '0;
      refill <= 1'b0;
    end else begin
      if (state == IDLE && bus.cpu_req) refill <= 1'b0;
      else if (fill_done) refill <= 1'b1;
      if (state == COMPARE && !refill && hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (state == COMPARE && !refill && !hit && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl_burst.sv
// tb_cache_ctrl_burst: randomized and directed checks of cache_ctrl_burst against a flat-memory reference model.
module tb_cache_ctrl_burst;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} beat_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] hit_count, miss_count;
  cache_ctrl_burst_if #(.ADDR_W(32), .DATA_W(32), .INDEX_W(8), .WORDS_PER_LINE(4)) bus ();
  cache_ctrl_burst #(.ADDR_W(32), .DATA_W(32), .INDEX_W(8), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  int vectors = 0, errs = 0;
  int mem_cycles, stall_mode, scnt, exp_hits, exp_misses;
  logic [31:0] rd_last;
  logic [31:0] dram [1024];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  logic [19:0] stag [256];
  bit sval [256], sdirty [256];
  beat_t log_q [$];
  logic prev_req, prev_rdy, prev_we;
  logic [31:0] prev_addr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask
  // power-on memory image; line 0x100 holds 0xA0..0xA3
  function automatic logic [31:0] init_v(input logic [31:0] a);
    return a[31:4] == 28'h10 ? 32'hA0 + {28'h0, a[3:2]} : {a[15:0], 16'h5A5A} ^ 32'h1357_0000;
  endfunction
  function automatic logic [31:0] bget(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_v(a);
  endfunction
  function automatic logic [31:0] rget(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_v(a);
  endfunction
  assign bus.ram_rdata = dram[bus.ram_addr];
  always @(posedge clk)
    if (bus.ram_we)
      for (int b = 0; b < 4; b++)
        if (bus.ram_be[b]) dram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
  // memory responder: decides mem_ready for the coming edge, logs accepted beats, checks stall stability
  always @(negedge clk) begin
    logic rdy;
    if (!bus.mem_req) rdy = 1'($urandom_range(0, 1));
    else if (stall_mode == 0) rdy = 1'b1;
    else if (stall_mode == 1) rdy = $urandom_range(0, 9) < 7;
    else rdy = scnt == 5;
    if (bus.mem_req) begin
      mem_cycles++;
      scnt = rdy ? 0 : scnt + 1;
      if (prev_req && !prev_rdy) begin
        chk("stall_addr", bus.mem_addr, prev_addr);
        chk("stall_we", {31'b0, bus.mem_we}, {31'b0, prev_we});
      end
      if (rdy) begin
        log_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
        if (bus.mem_we) bmem[bus.mem_addr] = bus.mem_wdata;
      end
    end
    bus.mem_ready = rdy;
    bus.mem_rdata = bget(bus.mem_addr);
    prev_req = bus.mem_req;
    prev_rdy = rdy;
    prev_we = bus.mem_we;
    prev_addr = bus.mem_addr;
  end
  task automatic chk_stats();
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
`else
    chk("hit_count", hit_count, 0);
    chk("miss_count", miss_count, 0);
`endif
  endtask
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] wa, la, nv;
    logic [7:0] idx;
    logic [19:0] tg;
    logic hit, wb;
    int cyc;
    beat_t e;
    beat_t exp_q [$];
    wa = {a[31:2], 2'b00};
    idx = a[11:4];
    tg = a[31:12];
    hit = sval[idx] && stag[idx] == tg;
    wb = !hit && sval[idx] && sdirty[idx];
    if (wb)
      for (int i = 0; i < 4; i++) begin
        la = {stag[idx], idx, i[1:0], 2'b00};
        e = {1'b1, la, rget(la)};
        exp_q.push_back(e);
      end
    if (!hit)
      for (int i = 0; i < 4; i++) begin
        e = {1'b0, tg, idx, i[1:0], 2'b00, 32'h0};
        exp_q.push_back(e);
      end
    if (hit) exp_hits++;
    else exp_misses++;
    @(negedge clk);
    log_q.delete();
    mem_cycles = 0;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = wd;
    bus.cpu_be = be;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cpu_ready && cyc < 500);
    rd_last = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
    chk("ready_seen", {31'b0, bus.cpu_ready}, 32'd1);
    chk("latency", cyc, hit ? 1 : 2 + mem_cycles);
    if (!we) chk("load_data", rd_last, rget(wa));
    chk("beat_count", log_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < log_q.size()) begin
        chk("beat_addr", log_q[i].addr, exp_q[i].addr);
        chk("beat_we", {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
        if (exp_q[i].we) chk("wb_data", log_q[i].data, exp_q[i].data);
      end
    if (!hit) begin
      stag[idx] = tg;
      sval[idx] = 1'b1;
      sdirty[idx] = 1'b0;
    end
    if (we) begin
      nv = rget(wa);
      for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = wd[8*b +: 8];
      rmem[wa] = nv;
      sdirty[idx] = 1'b1;
    end
    @(negedge clk);
    chk("ready_pulse", {31'b0, bus.cpu_ready}, 32'd0);
    chk_stats();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be = '0;
    stall_mode = 0;
    scnt = 0;
    exp_hits = 0;
    exp_misses = 0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", {31'b0, bus.cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    chk("rst_ram_be", {28'b0, bus.ram_be}, 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    chk_stats();
    rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
    chk("tp_fill_word1", rd_last, 32'hA1);
    chk("tp_fill_first_addr", log_q[0].addr, 32'h100);
    chk("tp_fill_last_addr", log_q[3].addr, 32'h10C);
    do_req(1'b0, 32'h0000_0108, 32'h0, 4'h0);
    chk("tp_hit_word2", rd_last, 32'hA2);
    do_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
    do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    chk("tp_partial_store", rd_last, 32'h0000_BEEF);
    do_req(1'b0, 32'h0001_0100, 32'h0, 4'h0);
    chk("tp_wb_first_data", log_q[0].data, 32'h0000_BEEF);
    chk("tp_fill_new_tag", log_q[4].addr, 32'h0001_0100);
    stall_mode = 2;
    scnt = 0;
    do_req(1'b0, 32'h0000_2204, 32'h0, 4'h0);
    chk("tp_stall_cycles", mem_cycles, 24);
    stall_mode = 1;
    for (int n = 0; n < 150; n++)
      do_req(1'($urandom_range(0, 1)),
             (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15)),
             $urandom, 4'($urandom_range(0, 15)));
    stall_mode = 0;
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h0000_3340;
    repeat (4) @(negedge clk);
    chk("rst_mid_beat2_addr", bus.mem_addr, 32'h0000_3348);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mid_cpu_ready", {31'b0, bus.cpu_ready}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sval[i] = 1'b0;
      sdirty[i] = 1'b0;
    end
    rmem = bmem;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);
    chk_stats();
    do_req(1'b0, 32'h0000_3340, 32'h0, 4'h0);
    do_req(1'b0, 32'h0000_3344, 32'h0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
